// File: rtl/duck_sprite_fetch.sv
// Per-pixel sprite fetch for one duck: beam/duck position to sprite-ROM address,
// three-stage pixel pipeline, and the fly/hit/fall animation state machine.
module duck_sprite_fetch #(
   parameter int SPRITE_W        = 39,
   parameter int SPRITE_H        = 39,
   parameter int NUM_FRAMES      = 3,
   parameter int FRAME_DIV       = 8,
   parameter int HIT_TICKS       = 30,
   parameter int TRANSPARENT_IDX = 0,
   parameter int ADDR_W          = 13
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_tick,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        duck_x,
   input  logic [9:0]        duck_y,
   input  logic              duck_active,
   input  logic              duck_hit,
   input  logic              dir_left,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_data,
   output logic [3:0]        pixel_index,
   output logic              pixel_valid,
   output logic [1:0]        anim_state
);

   localparam int FRAME_SZ = SPRITE_W * SPRITE_H;
   localparam int FLAP_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int TICK_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int HIT_W    = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
   localparam int FRAME_W  = $clog2(NUM_FRAMES + 2);

   typedef enum logic [1:0] {
      FLY  = 2'd0,
      HIT  = 2'd1,
      FALL = 2'd2
   } anim_t;

   anim_t               state_r, state_n_s;
   logic [FLAP_W-1:0]   flap_r, flap_n_s;
   logic [TICK_W-1:0]   tick_cnt_r, tick_cnt_n_s;
   logic [HIT_W-1:0]    hit_cnt_r, hit_cnt_n_s;
   logic [FRAME_W-1:0]  cur_frame_s;
   logic [10:0]         bx_s, by_s, px_s, py_s, dx_s, dy_s, col_s;
   logic                inside_s;
   logic [ADDR_W-1:0]   addr_s;
   logic                inside_d1_r, inside_d2_r;

   // 11-bit operands so duck_x + SPRITE_W cannot wrap near the screen edge
   assign bx_s = {1'b0, DrawX};
   assign by_s = {1'b0, DrawY};
   assign px_s = {1'b0, duck_x};
   assign py_s = {1'b0, duck_y};

   assign inside_s = duck_active
                   & (bx_s >= px_s) & (bx_s < px_s + 11'(SPRITE_W))
                   & (by_s >= py_s) & (by_s < py_s + 11'(SPRITE_H));

   // ROM frame selected by the animation state
   always_comb begin
      cur_frame_s = {FRAME_W{1'b0}};
      case (state_r)
         FLY:     cur_frame_s = FRAME_W'(flap_r);
         HIT:     cur_frame_s = FRAME_W'(NUM_FRAMES);
         FALL:    cur_frame_s = FRAME_W'(NUM_FRAMES + 1);
         default: cur_frame_s = {FRAME_W{1'b0}};
      endcase
   end

   // sprite-relative row/column (mirrored when facing left) and ROM address
   always_comb begin
      dx_s = bx_s - px_s;
      dy_s = by_s - py_s;
      if (dir_left) begin
         col_s = 11'(SPRITE_W - 1) - dx_s;
      end else begin
         col_s = dx_s;
      end
      if (inside_s) begin
         addr_s = ADDR_W'(cur_frame_s) * ADDR_W'(FRAME_SZ)
                + ADDR_W'(dy_s) * ADDR_W'(SPRITE_W)
                + ADDR_W'(col_s);
      end else begin
         addr_s = {ADDR_W{1'b0}};
      end
   end

   // address stage, ROM-wait stage and pixel output stage
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr    <= {ADDR_W{1'b0}};
         inside_d1_r <= 1'b0;
         inside_d2_r <= 1'b0;
         pixel_index <= 4'd0;
         pixel_valid <= 1'b0;
      end else begin
         rom_addr    <= addr_s;
         inside_d1_r <= inside_s;
         inside_d2_r <= inside_d1_r;
         pixel_index <= inside_d2_r ? rom_data : 4'd0;
         pixel_valid <= inside_d2_r & (rom_data != 4'(TRANSPARENT_IDX));
      end
   end

   // animation state and counters
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r    <= FLY;
         flap_r     <= {FLAP_W{1'b0}};
         tick_cnt_r <= {TICK_W{1'b0}};
         hit_cnt_r  <= {HIT_W{1'b0}};
      end else begin
         state_r    <= state_n_s;
         flap_r     <= flap_n_s;
         tick_cnt_r <= tick_cnt_n_s;
         hit_cnt_r  <= hit_cnt_n_s;
      end
   end

   // next-state: duck_active=0 beats everything, a hit beats a same-cycle tick
   always_comb begin
      state_n_s    = state_r;
      flap_n_s     = flap_r;
      tick_cnt_n_s = tick_cnt_r;
      hit_cnt_n_s  = hit_cnt_r;
      if (!duck_active) begin
         state_n_s    = FLY;
         flap_n_s     = {FLAP_W{1'b0}};
         tick_cnt_n_s = {TICK_W{1'b0}};
         hit_cnt_n_s  = {HIT_W{1'b0}};
      end else begin
         case (state_r)
            FLY: begin
               if (duck_hit) begin
                  state_n_s   = HIT;
                  hit_cnt_n_s = {HIT_W{1'b0}};
               end else if (frame_tick) begin
                  if (tick_cnt_r == TICK_W'(FRAME_DIV - 1)) begin
                     tick_cnt_n_s = {TICK_W{1'b0}};
                     if (flap_r == FLAP_W'(NUM_FRAMES - 1)) begin
                        flap_n_s = {FLAP_W{1'b0}};
                     end else begin
                        flap_n_s = flap_r + FLAP_W'(1);
                     end
                  end else begin
                     tick_cnt_n_s = tick_cnt_r + TICK_W'(1);
                  end
               end else begin
                  state_n_s = FLY;
               end
            end
            HIT: begin
               if (frame_tick) begin
                  if (hit_cnt_r == HIT_W'(HIT_TICKS - 1)) begin
                     state_n_s   = FALL;
                     hit_cnt_n_s = {HIT_W{1'b0}};
                  end else begin
                     hit_cnt_n_s = hit_cnt_r + HIT_W'(1);
                  end
               end else begin
                  state_n_s = HIT;
               end
            end
            FALL:    state_n_s = FALL;
            default: begin
               state_n_s    = FLY;
               flap_n_s     = {FLAP_W{1'b0}};
               tick_cnt_n_s = {TICK_W{1'b0}};
               hit_cnt_n_s  = {HIT_W{1'b0}};
            end
         endcase
      end
   end

   assign anim_state = state_r;

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Directed bench for duck_sprite_fetch with a synchronous sprite-ROM model.
module tb_duck_sprite_fetch;

   logic        Clk, Reset, frame_tick, duck_active, duck_hit, dir_left;
   logic [9:0]  DrawX, DrawY, duck_x, duck_y;
   logic [12:0] rom_addr;
   logic [3:0]  rom_data, pixel_index;
   logic        pixel_valid;
   logic [1:0]  anim_state;

   logic        rom_ov_en;
   logic [3:0]  rom_ov_val;
   int          n_cmp, n_bad;

   duck_sprite_fetch dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
      .DrawX(DrawX), .DrawY(DrawY), .duck_x(duck_x), .duck_y(duck_y),
      .duck_active(duck_active), .duck_hit(duck_hit), .dir_left(dir_left),
      .rom_addr(rom_addr), .rom_data(rom_data), .pixel_index(pixel_index),
      .pixel_valid(pixel_valid), .anim_state(anim_state)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // one-cycle synchronous ROM; default content is never transparent
   always @(posedge Clk) rom_data <= rom_ov_en ? rom_ov_val : (rom_addr[3:0] | 4'h1);

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic pulse_ticks(input int n);
      repeat (n) begin
         frame_tick = 1'b1; tick(1);
         frame_tick = 1'b0; tick(1);
      end
   endtask

   // reference address for a duck at (100,50)
   function automatic int exp_addr(input int x, input int y, input int dl, input int fr);
      int c, r;
      if (x < 100 || x >= 139 || y < 50 || y >= 89) return 0;
      c = x - 100;
      if (dl != 0) c = 38 - c;
      r = y - 50;
      return fr * 1521 + r * 39 + c;
   endfunction

   task automatic test_reset;
      DrawX = 10'd105; DrawY = 10'd52; duck_active = 1'b1;
      tick(4);
      n_cmp++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got %0b want 1", pixel_valid); end
      Reset = 1'b1; tick(1);
      n_cmp++; if (rom_addr !== 13'd0) begin n_bad++; $display("FAIL rst_rom_addr got %0d want 0", rom_addr); end
      n_cmp++; if (pixel_index !== 4'd0) begin n_bad++; $display("FAIL rst_pixel_index got %0d want 0", pixel_index); end
      n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pixel_valid got %0b want 0", pixel_valid); end
      n_cmp++; if (anim_state !== 2'd0) begin n_bad++; $display("FAIL rst_anim_state got %0d want 0", anim_state); end
      tick(1); Reset = 1'b0;
      tick(1);
      n_cmp++; if (rom_addr !== 13'd83) begin n_bad++; $display("FAIL post_rst_addr got %0d want 83", rom_addr); end
      n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid1 got %0b want 0", pixel_valid); end
      tick(1);
      n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid2 got %0b want 0", pixel_valid); end
      tick(1);
      n_cmp++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL post_rst_valid3 got %0b want 1", pixel_valid); end
   endtask

   task automatic test_addressing;
      rom_ov_en = 1'b1; rom_ov_val = 4'd7;
      DrawX = 10'd105; DrawY = 10'd52; dir_left = 1'b0;
      tick(1);
      n_cmp++; if (rom_addr !== 13'd83) begin n_bad++; $display("FAIL addr_right got %0d want 83", rom_addr); end
      tick(2);
      n_cmp++; if (pixel_index !== 4'd7) begin n_bad++; $display("FAIL index_right got %0d want 7", pixel_index); end
      n_cmp++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL valid_right got %0b want 1", pixel_valid); end
      dir_left = 1'b1;
      tick(1);
      n_cmp++; if (rom_addr !== 13'd111) begin n_bad++; $display("FAIL addr_left got %0d want 111", rom_addr); end
      tick(2);
      n_cmp++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL valid_left got %0b want 1", pixel_valid); end
      dir_left = 1'b0; rom_ov_en = 1'b0;
   endtask

   task automatic test_clipping;
      logic [9:0] xs [2];
      xs[0] = 10'd99; xs[1] = 10'd139;
      for (int k = 0; k < 2; k++) begin
         DrawX = xs[k]; DrawY = 10'd52;
         tick(3);
         n_cmp++; if (rom_addr !== 13'd0) begin n_bad++; $display("FAIL clip_addr x=%0d got %0d want 0", xs[k], rom_addr); end
         n_cmp++; if (pixel_valid !== 1'b0 || pixel_index !== 4'd0) begin n_bad++; $display("FAIL clip_pixel x=%0d got v=%0b i=%0d want v=0 i=0", xs[k], pixel_valid, pixel_index); end
      end
      DrawX = 10'd138;
      tick(1);
      n_cmp++; if (rom_addr !== 13'd116) begin n_bad++; $display("FAIL edge_addr got %0d want 116", rom_addr); end
      tick(2);
      n_cmp++; if (pixel_valid !== 1'b1 || pixel_index !== 4'd5) begin n_bad++; $display("FAIL edge_pixel got v=%0b i=%0d want v=1 i=5", pixel_valid, pixel_index); end
      DrawY = 10'd89;
      tick(3);
      n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL clip_bottom got %0b want 0", pixel_valid); end
      rom_ov_en = 1'b1; rom_ov_val = 4'd0; DrawX = 10'd105; DrawY = 10'd52;
      tick(3);
      n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL transparent got %0b want 0", pixel_valid); end
      rom_ov_en = 1'b0;
   endtask

   task automatic test_animation;
      DrawX = 10'd100; DrawY = 10'd50;
      pulse_ticks(7);
      n_cmp++; if (rom_addr !== 13'd0) begin n_bad++; $display("FAIL anim_7ticks got %0d want 0", rom_addr); end
      pulse_ticks(1);
      n_cmp++; if (rom_addr !== 13'd1521) begin n_bad++; $display("FAIL anim_8ticks got %0d want 1521", rom_addr); end
      pulse_ticks(8);
      n_cmp++; if (rom_addr !== 13'd3042) begin n_bad++; $display("FAIL anim_16ticks got %0d want 3042", rom_addr); end
      pulse_ticks(8);
      n_cmp++; if (rom_addr !== 13'd0) begin n_bad++; $display("FAIL anim_wrap got %0d want 0", rom_addr); end
      n_cmp++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL anim_wrap_valid got %0b want 1", pixel_valid); end
   endtask

   task automatic test_hit_fall;
      frame_tick = 1'b1; duck_hit = 1'b1; tick(1);
      frame_tick = 1'b0; duck_hit = 1'b0;
      n_cmp++; if (anim_state !== 2'd1) begin n_bad++; $display("FAIL hit_state got %0d want 1", anim_state); end
      tick(1);
      n_cmp++; if (rom_addr !== 13'd4563) begin n_bad++; $display("FAIL hit_addr got %0d want 4563", rom_addr); end
      pulse_ticks(29);
      n_cmp++; if (anim_state !== 2'd1) begin n_bad++; $display("FAIL hit_held got %0d want 1", anim_state); end
      pulse_ticks(1);
      n_cmp++; if (anim_state !== 2'd2) begin n_bad++; $display("FAIL fall_state got %0d want 2", anim_state); end
      n_cmp++; if (rom_addr !== 13'd6084) begin n_bad++; $display("FAIL fall_addr got %0d want 6084", rom_addr); end
      duck_hit = 1'b1; tick(1); duck_hit = 1'b0; tick(1);
      n_cmp++; if (anim_state !== 2'd2 || rom_addr !== 13'd6084) begin n_bad++; $display("FAIL rehit got s=%0d a=%0d want s=2 a=6084", anim_state, rom_addr); end
   endtask

   task automatic test_deactivate;
      duck_active = 1'b0; tick(1);
      n_cmp++; if (anim_state !== 2'd0) begin n_bad++; $display("FAIL deact_state got %0d want 0", anim_state); end
      n_cmp++; if (rom_addr !== 13'd0) begin n_bad++; $display("FAIL deact_addr got %0d want 0", rom_addr); end
      tick(2);
      n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL deact_valid got %0b want 0", pixel_valid); end
      duck_active = 1'b1; DrawX = 10'd101; tick(1);
      n_cmp++; if (rom_addr !== 13'd1) begin n_bad++; $display("FAIL react_frame0 got %0d want 1", rom_addr); end
   endtask

   task automatic test_back_to_back;
      int xs [10];
      int a;
      logic [12:0] av;
      logic [3:0] ei;
      logic ev;
      for (int i = 0; i < 10; i++) xs[i] = (i < 8) ? 97 + i : 0;
      DrawY = 10'd52; dir_left = 1'b0;
      for (int i = 0; i < 10; i++) begin
         DrawX = 10'(xs[i]);
         tick(1);
         a = exp_addr(xs[i], 52, 0, 0);
         n_cmp++; if (rom_addr !== 13'(a)) begin n_bad++; $display("FAIL stream_addr x=%0d got %0d want %0d", xs[i], rom_addr, a); end
         if (i >= 2) begin
            ev = (xs[i-2] >= 100 && xs[i-2] < 139);
            av = 13'(exp_addr(xs[i-2], 52, 0, 0));
            ei = ev ? (av[3:0] | 4'h1) : 4'h0;
            n_cmp++; if (pixel_valid !== ev || pixel_index !== ei) begin n_bad++; $display("FAIL stream_pixel x=%0d got v=%0b i=%0d want v=%0b i=%0d", xs[i-2], pixel_valid, pixel_index, ev, ei); end
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      Reset = 1'b1; frame_tick = 1'b0; duck_hit = 1'b0; dir_left = 1'b0;
      duck_active = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
      duck_x = 10'd100; duck_y = 10'd50;
      rom_ov_en = 1'b0; rom_ov_val = 4'd0;
      tick(2);
      Reset = 1'b0;
      test_reset();
      test_addressing();
      test_clipping();
      test_animation();
      test_hit_fall();
      test_deactivate();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
